// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol width and the four control tokens.
// Used by the channel-bonding block and reused by the 10b/8b decoder.
package tmds_pkg;

  localparam int DW = 10;

  localparam logic [DW-1:0] CTRLTOKEN0 = 10'h354;
  localparam logic [DW-1:0] CTRLTOKEN1 = 10'h0AB;
  localparam logic [DW-1:0] CTRLTOKEN2 = 10'h154;
  localparam logic [DW-1:0] CTRLTOKEN3 = 10'h2AB;

  function automatic logic is_ctrl_token(input logic [DW-1:0] sym);
    return (sym == CTRLTOKEN0) || (sym == CTRLTOKEN1) ||
           (sym == CTRLTOKEN2) || (sym == CTRLTOKEN3);
  endfunction

endpackage

// File: rtl/chnlbond_fifo.sv
// Deskew buffer for one TMDS channel: 2^AW x DW RAM, synchronous write,
// asynchronous read. Contents are intentionally not reset.
module chnlbond_fifo #(
  parameter int AW = 4,
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_wa,
  input  logic [DW-1:0] i_wd,
  input  logic [AW-1:0] i_ra,
  output logic [DW-1:0] o_rd
);

  logic [DW-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wa] <= i_wd;
  end

  assign o_rd = r_mem[i_ra];

endmodule

// File: rtl/chnlbond.sv
// Per-channel TMDS deskew: parks the read pointer on the second blanking start
// and releases all three channels together. Optional macro: CHNLBOND_OVF_EN.
module chnlbond
  import tmds_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] rawdata,
  input  logic          iamvld,
  input  logic          other_ch0_vld,
  input  logic          other_ch1_vld,
  input  logic          other_ch0_rdy,
  input  logic          other_ch1_rdy,
  output logic          iamrdy,
  output logic [DW-1:0] sdata
`ifdef CHNLBOND_OVF_EN
  ,
  output logic          ovf
`endif
);

  logic          w_vld;
  logic          w_all_rdy;
  logic          w_vld_rise;
  logic          w_rcvd_ctkn;
  logic          w_blnkbgn;
  logic          w_next_blnkbgn;
  logic [DW-1:0] w_rd;

  logic [AW-1:0] r_wa;
  logic [AW-1:0] r_ra;
  logic [DW-1:0] r_sdata;
  logic          r_iamrdy;
  logic          r_skip_line;
  logic          r_ra_en;
  logic          r_rcvd_ctkn_q;
  logic          r_rawdata_vld_q;

  assign w_vld          = iamvld & other_ch0_vld & other_ch1_vld;
  assign w_all_rdy      = r_iamrdy & other_ch0_rdy & other_ch1_rdy;
  assign w_vld_rise     = w_vld & ~r_rawdata_vld_q;
  assign w_rcvd_ctkn    = is_ctrl_token(r_sdata);
  assign w_blnkbgn      = w_rcvd_ctkn & ~r_rcvd_ctkn_q;
  assign w_next_blnkbgn = r_skip_line & w_blnkbgn;

  chnlbond_fifo #(
    .AW (AW),
    .DW (DW)
  ) u_fifo (
    .clk  (clk),
    .i_we (w_vld),
    .i_wa (r_wa),
    .i_wd (rawdata),
    .i_ra (r_ra),
    .o_rd (w_rd)
  );

  // Writer free-runs while valid; reader restarts at 0 whenever valid drops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wa <= '0;
      r_ra <= '0;
    end else begin
      if (w_vld) r_wa <= r_wa + AW'(1);
      if (!w_vld)       r_ra <= '0;
      else if (r_ra_en) r_ra <= r_ra + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sdata         <= '0;
      r_rcvd_ctkn_q   <= 1'b0;
      r_rawdata_vld_q <= 1'b0;
    end else begin
      r_sdata         <= w_rd;
      r_rcvd_ctkn_q   <= w_rcvd_ctkn;
      r_rawdata_vld_q <= w_vld;
    end
  end

  // First blanking only arms skip_line, so bonding lands on a full line boundary.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_skip_line <= 1'b0;
      r_iamrdy    <= 1'b0;
      r_ra_en     <= 1'b0;
    end else if (!w_vld) begin
      r_skip_line <= 1'b0;
      r_iamrdy    <= 1'b0;
      r_ra_en     <= 1'b0;
    end else begin
      if (w_blnkbgn)      r_skip_line <= 1'b1;
      if (w_next_blnkbgn) r_iamrdy    <= 1'b1;
      if (w_vld_rise || w_all_rdy) r_ra_en <= 1'b1;
      else if (w_next_blnkbgn)     r_ra_en <= 1'b0;
    end
  end

  assign iamrdy = r_iamrdy;
  assign sdata  = r_sdata;

`ifdef CHNLBOND_OVF_EN
  logic w_ovf_hit;
  logic r_ovf;

  // Parked reader is about to be overwritten by the free-running writer.
  assign w_ovf_hit = w_vld & ~r_ra_en & ((r_wa + AW'(1)) == r_ra);

  always_ff @(posedge clk) begin
    if (!reset_n)       r_ovf <= 1'b0;
    else if (!w_vld)    r_ovf <= 1'b0;
    else if (w_ovf_hit) r_ovf <= 1'b1;
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_chnlbond.sv
// Bench for chnlbond: one standalone instance plus three cross-wired skewed
// instances; data order is tracked with a scoreboard queue.
module tb_chnlbond;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Standalone instance
  logic       s_rst_n, s_iamvld, s_o0v, s_o1v, s_o0r, s_o1r;
  logic [9:0] s_raw;
  logic       s_iamrdy;
  logic [9:0] s_sdata;
  logic       s_sb_en;
  int         s_nedge;
  logic [9:0] q_s[$];
`ifdef CHNLBOND_OVF_EN
  logic       s_ovf;
`endif

  chnlbond u_s (
    .clk           (clk),
    .reset_n       (s_rst_n),
    .rawdata       (s_raw),
    .iamvld        (s_iamvld),
    .other_ch0_vld (s_o0v),
    .other_ch1_vld (s_o1v),
    .other_ch0_rdy (s_o0r),
    .other_ch1_rdy (s_o1r),
    .iamrdy        (s_iamrdy),
    .sdata         (s_sdata)
`ifdef CHNLBOND_OVF_EN
    ,
    .ovf           (s_ovf)
`endif
  );

  // Three cross-wired instances
  logic       c_rst_n, c_vld;
  logic [9:0] c_r0, c_r1, c_r2;
  logic [9:0] c_sd0, c_sd1, c_sd2;
  logic       c_rdy0, c_rdy1, c_rdy2;
  logic [9:0] q_c[$];
`ifdef CHNLBOND_OVF_EN
  logic       c_ovf0, c_ovf1, c_ovf2;
`endif

  chnlbond u_c0 (
    .clk (clk), .reset_n (c_rst_n), .rawdata (c_r0), .iamvld (c_vld),
    .other_ch0_vld (c_vld), .other_ch1_vld (c_vld),
    .other_ch0_rdy (c_rdy1), .other_ch1_rdy (c_rdy2),
    .iamrdy (c_rdy0), .sdata (c_sd0)
`ifdef CHNLBOND_OVF_EN
    , .ovf (c_ovf0)
`endif
  );

  chnlbond u_c1 (
    .clk (clk), .reset_n (c_rst_n), .rawdata (c_r1), .iamvld (c_vld),
    .other_ch0_vld (c_vld), .other_ch1_vld (c_vld),
    .other_ch0_rdy (c_rdy0), .other_ch1_rdy (c_rdy2),
    .iamrdy (c_rdy1), .sdata (c_sd1)
`ifdef CHNLBOND_OVF_EN
    , .ovf (c_ovf1)
`endif
  );

  chnlbond u_c2 (
    .clk (clk), .reset_n (c_rst_n), .rawdata (c_r2), .iamvld (c_vld),
    .other_ch0_vld (c_vld), .other_ch1_vld (c_vld),
    .other_ch0_rdy (c_rdy0), .other_ch1_rdy (c_rdy1),
    .iamrdy (c_rdy2), .sdata (c_sd2)
`ifdef CHNLBOND_OVF_EN
    , .ovf (c_ovf2)
`endif
  );

  function automatic bit is_tok(input logic [9:0] v);
    return (v == 10'h354) || (v == 10'h0AB) || (v == 10'h154) || (v == 10'h2AB);
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] v;
    v = 10'($urandom_range(0, 1023));
    while (is_tok(v)) v = 10'($urandom_range(0, 1023));
    return v;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one symbol into the standalone instance, then check its output.
  task automatic step_s(input logic [9:0] sym, input string tag);
    logic [9:0] e;
    s_raw = sym;
    if (s_iamvld && s_o0v && s_o1v && s_sb_en && !is_tok(sym)) q_s.push_back(sym);
    @(posedge clk);
    #1;
    s_nedge++;
    if (s_sb_en && s_nedge >= 2 && !is_tok(s_sdata)) begin
      if (q_s.size() == 0) chk({tag, "_sb_empty"}, 16'(q_s.size()), 16'd1);
      else begin
        e = q_s.pop_front();
        chk(tag, 16'(s_sdata), 16'(e));
      end
    end
  endtask

  task automatic reset_s();
    s_rst_n  = 1'b0;
    s_iamvld = 1'b1;
    s_o0v    = 1'b1;
    s_o1v    = 1'b1;
    s_raw    = rand_data();
    @(posedge clk);
    #1;
    chk("rst_sdata", 16'(s_sdata), 16'd0);
    chk("rst_iamrdy", 16'(s_iamrdy), 16'd0);
`ifdef CHNLBOND_OVF_EN
    chk("rst_ovf", 16'(s_ovf), 16'd0);
`endif
    s_raw = rand_data();
    @(posedge clk);
    #1;
    s_rst_n = 1'b1;
    q_s.delete();
    s_nedge = 0;
  endtask

  task automatic run_bond(input logic [9:0] tok_a, input logic [9:0] tok_b,
                          input bit expect_rdy, input string tag);
    logic [9:0] sym;
    s_o0r = 1'b1;
    s_o1r = 1'b1;
    reset_s();
    s_sb_en = 1'b1;
    for (int i = 0; i < 34; i++) begin
      if (i >= 10 && i < 14)      sym = tok_a;
      else if (i >= 24 && i < 28) sym = tok_b;
      else                        sym = rand_data();
      step_s(sym, {tag, "_data"});
      chk({tag, "_rdy"}, 16'(s_iamrdy), 16'(expect_rdy && (i >= 26)));
    end
  endtask

  initial begin
    logic [9:0] sym;
    logic [9:0] hist[8];
    logic [9:0] e;
    int         cn;
    int         bidx;
    bit         bonded;

    s_rst_n = 1'b0; s_iamvld = 1'b0; s_o0v = 1'b0; s_o1v = 1'b0;
    s_o0r = 1'b1; s_o1r = 1'b1; s_raw = '0; s_sb_en = 1'b1; s_nedge = 0;
    c_rst_n = 1'b0; c_vld = 1'b1; c_r0 = '0; c_r1 = '0; c_r2 = '0;

    // Reset, then single-channel bond with in-order data check
    reset_s();
    for (int i = 0; i < 90; i++) begin
      if ((i >= 20 && i < 24) || (i >= 54 && i < 58)) sym = 10'h354;
      else                                             sym = rand_data();
      step_s(sym, "s1_data");
      chk("s1_rdy", 16'(s_iamrdy), 16'(i >= 56));
    end

    // Loss of valid for one cycle after bonding
    s_o0v = 1'b0;
    step_s(rand_data(), "loss_data");
    chk("loss_rdy", 16'(s_iamrdy), 16'd0);
    chk("loss_ra", 16'(u_s.r_ra), 16'd0);
    s_o0v   = 1'b1;
    s_sb_en = 1'b0;
    for (int i = 0; i < 68; i++) begin
      if ((i >= 20 && i < 24) || (i >= 44 && i < 48)) sym = 10'h354;
      else                                             sym = rand_data();
      step_s(sym, "loss2_data");
      if (i <= 43) chk("loss_rdy_hold", 16'(s_iamrdy), 16'd0);
      if (i == 67) chk("loss_rebond", 16'(s_iamrdy), 16'd1);
    end

    // Token variety and a non-token lookalike
    run_bond(10'h0AB, 10'h154, 1'b1, "tok_0ab_154");
    run_bond(10'h2AB, 10'h2AB, 1'b1, "tok_2ab");
    run_bond(10'h2CC, 10'h2CC, 1'b0, "tok_2cc");

    // Three skewed channels
    c_vld = 1'b1;
    c_r0 = rand_data(); c_r1 = rand_data(); c_r2 = rand_data();
    @(posedge clk);
    #1;
    chk("c_rst_sdata", 16'(c_sd0), 16'd0);
    @(posedge clk);
    #1;
    c_rst_n = 1'b1;
    for (int k = 0; k < 8; k++) hist[k] = rand_data();
    q_c.delete();
    cn = 0; bidx = -1; bonded = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if ((i >= 20 && i < 24) || (i >= 54 && i < 58)) sym = 10'h354;
      else                                             sym = rand_data();
      c_r0 = sym;
      c_r1 = hist[2];
      c_r2 = hist[4];
      for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = sym;
      if (!is_tok(sym)) q_c.push_back(sym);
      @(posedge clk);
      #1;
      cn++;
      if (cn >= 2 && !is_tok(c_sd0)) begin
        if (q_c.size() == 0) chk("skew_sb_empty", 16'(q_c.size()), 16'd1);
        else begin
          e = q_c.pop_front();
          chk("skew_c0_data", 16'(c_sd0), 16'(e));
        end
      end
      if (bonded) begin
        chk("skew_c1_vs_c0", 16'(c_sd1), 16'(c_sd0));
        chk("skew_c2_vs_c0", 16'(c_sd2), 16'(c_sd0));
      end else if (c_rdy0 && c_rdy1 && c_rdy2) begin
        bonded = 1'b1;
        bidx   = i;
        chk("skew_tok_c0", 16'(c_sd0), 16'h354);
        chk("skew_tok_c1", 16'(c_sd1), 16'h354);
        chk("skew_tok_c2", 16'(c_sd2), 16'h354);
      end
    end
    chk("skew_bond_idx", 16'(bidx), 16'd61);

`ifdef CHNLBOND_OVF_EN
    // Parked reader with other channels never ready
    s_o0r = 1'b0;
    s_o1r = 1'b0;
    reset_s();
    s_sb_en = 1'b0;
    for (int i = 0; i < 51; i++) begin
      if ((i >= 10 && i < 14) || (i >= 24 && i < 28)) sym = 10'h354;
      else                                             sym = rand_data();
      step_s(sym, "ovf_data");
      chk("ovf_rdy", 16'(s_iamrdy), 16'(i >= 26));
      chk("ovf_flag", 16'(s_ovf), 16'(i >= 41));
    end
    s_iamvld = 1'b0;
    step_s(rand_data(), "ovf_drop");
    chk("ovf_clear", 16'(s_ovf), 16'd0);
    chk("ovf_drop_rdy", 16'(s_iamrdy), 16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/chnlbond.md
Name: chnlbond

Overview:
- Per-channel deskew (channel-bonding) block for a 3-channel TMDS/HDMI receiver.
- Each channel instance buffers eye-aligned 10-bit symbols in a small circular FIFO.
- All three channels align their read pointers on the first control token of a blanking period, so the three `sdata` streams leave symbol-aligned.
- Sits between the per-channel bit/word aligner and the 10b/8b decoder; one instance per TMDS channel, cross-wired via the `other_*` ports.

Parameters:
- AW, 4, FIFO address width; depth = 2^AW = 16 entries.
- DW, 10, symbol width.

Ports:
- clk  in  1  pixel clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- rawdata  in  DW  eye-aligned raw TMDS symbol for this channel.
- iamvld  in  1  this channel's word aligner has valid data.
- other_ch0_vld  in  1  first other channel has valid data.
- other_ch1_vld  in  1  second other channel has valid data.
- other_ch0_rdy  in  1  first other channel has found its bonding point.
- other_ch1_rdy  in  1  second other channel has found its bonding point.
- iamrdy  out  1  this channel has found its bonding point (registered).
- sdata  out  DW  deskewed symbol (registered).

Behaviour:
- Constants: CTRLTOKEN0=10'h354, CTRLTOKEN1=10'h0AB, CTRLTOKEN2=10'h154, CTRLTOKEN3=10'h2AB.
- Reset (reset_n=0 at an edge) clears wa, ra, sdata, iamrdy, skip_line, ra_en, rcvd_ctkn_q, rawdata_vld_q and ovf to 0. FIFO contents are not reset.
- vld = iamvld & other_ch0_vld & other_ch1_vld (combinational).
- all_rdy = iamrdy & other_ch0_rdy & other_ch1_rdy.
- Write side: when vld=1, mem[wa] <= rawdata and wa <= wa+1, wrapping mod 2^AW. When vld=0, wa holds.
- Read side: mem is read asynchronously at ra. Each edge, sdata <= mem[ra] using contents before that edge's write (read-before-write). sdata updates every cycle regardless of vld.
- When vld=0, ra <= 0; otherwise ra <= ra+1 (wrap) iff ra_en=1.
- rcvd_ctkn = (sdata == any CTRLTOKENn).
- rcvd_ctkn_q <= rcvd_ctkn each cycle.
- blnkbgn = rcvd_ctkn & ~rcvd_ctkn_q: first control token after non-control data.
- skip_line <= 0 if vld=0; else 1 if blnkbgn; else hold. The first blanking seen is discarded so that bonding happens on a complete line boundary.
- next_blnkbgn = skip_line & blnkbgn.
- iamrdy <= 0 if vld=0; else 1 if next_blnkbgn; else hold (sticky while vld).
- rawdata_vld_q <= vld; vld_rise = vld & ~rawdata_vld_q.
- ra_en, priority order:
  - vld=0 -> 0;
  - else vld_rise or all_rdy -> 1;
  - else next_blnkbgn -> 0 (this channel parks its read pointer on its blanking start);
  - else hold.
- Alignment result: each channel parks at its own blanking start. Once all three are rdy, ra_en resumes together and the outputs stay aligned.
- Skew tolerance: less than 2^AW symbols. Larger skew silently overwrites unread data.
- Losing vld at any time (including mid-alignment) restarts alignment: ra=0, iamrdy=0, skip_line=0, ra_en=0. wa keeps its value.
- Simultaneous vld_rise and next_blnkbgn: ra_en=1 (rise wins).

Optional Feature:
- Macro CHNLBOND_OVF_EN.
- When defined, adds output `ovf` (1 bit, registered):
  - set when vld=1, ra_en=0 and (wa+1)==ra mod 2^AW, i.e. the parked reader is about to be overwritten;
  - sticky; cleared by reset or vld=0.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package `tmds_pkg`: the four CTRLTOKEN constants and DW. The decoder reuses them.
- One natural sub-module `chnlbond_fifo`: 2^AW x DW RAM with synchronous write and asynchronous read. Pointer and bonding control stay in the top.

Test Plan:
- Reset: reset_n=0 for 2 cycles with random rawdata -> sdata=0, iamrdy=0 and (if enabled) ovf=0 after the first edge.
- Single-channel bond: other_* tied 1; iamvld=1; stream 20 data symbols, 4 x 10'h354, 30 data, 4 x 10'h354 -> iamrdy rises only after the second blanking start. sdata then continues in order (ra_en re-enabled via all_rdy), with no symbol dropped or duplicated.
- Three-instance skew: cross-wired channels; ch1 delayed 3 symbols, ch2 delayed 5 -> after all iamrdy=1, all three sdata show 10'h354 on the same cycle and subsequent data match cycle-for-cycle.
- Loss of valid: drop other_ch0_vld for 1 cycle after bonding -> iamrdy=0 next edge; ra=0; re-bonding requires two more blanking starts.
- Token variety: blanking beginning with 10'h0AB, 10'h154, 10'h2AB each -> detected as blanking start identically to 10'h354. A data symbol such as 10'h2CC is not detected.
- Overflow (CHNLBOND_OVF_EN): other channels never rdy, this channel parked, vld held 16 more cycles -> ovf=1 and stays 1 until vld drops.
